// File: rtl/aq_reduce_pkg.sv
// Shared parameters, state encoding and constants for the area-averaging
// reducer accumulation stage.
package aq_reduce_pkg;

  localparam int CH_DEF = 3;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 24;
  localparam int RW_DEF = 24;

  // Largest value a DW_DEF-bit channel can carry after normalization.
  localparam int unsigned SAT_MAX = (1 << DW_DEF) - 1;

  typedef enum logic {
    ACC   = 1'b0,
    FLUSH = 1'b1
  } aq_state_e;

endpackage

// File: rtl/aq_reduce_norm.sv
// One channel of the normalizer: multiply by the reciprocal, round to nearest,
// then saturate to the channel width.
module aq_reduce_norm #(
  parameter int AW = 24,
  parameter int RW = 24,
  parameter int DW = 8
) (
  input  logic [AW-1:0] sum,
  input  logic [RW-1:0] rcp,
  output logic [DW-1:0] y
);

  // One spare bit so the rounding add can never wrap.
  localparam int PW = AW + RW + 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] rounded;
  logic [AW:0]   q;

  assign prod    = PW'(sum) * PW'(rcp);
  assign rounded = prod + (PW'(1) << (RW - 1));
  assign q       = (AW + 1)'(rounded >> RW);
  assign y       = (|q[AW:DW]) ? {DW{1'b1}} : q[DW-1:0];

endmodule

// File: rtl/aq_reduce_accum.sv
// Weighted accumulation of split-weighted pixels into reduced output pixels,
// with a one-deep registered output and a flush for the residual at line end.
module aq_reduce_accum
  import aq_reduce_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [RW-1:0]  RCP,
  input  logic           W_VALID,
  input  logic [15:0]    W_A,
  input  logic [15:0]    W_B,
  output logic           W_ENA,
  input  logic           S_VALID,
  output logic           S_READY,
  input  logic [CH*DW-1:0] S_TDATA,
  input  logic           S_TLAST,
  output logic           M_VALID,
  input  logic           M_READY,
  output logic [CH*DW-1:0] M_TDATA,
  output logic           M_TLAST,
  output aq_state_e      dbg_state
);

  aq_state_e     state, state_nxt;
  logic [AW-1:0] acc      [CH];
  logic [AW-1:0] acc_base [CH];
  logic [AW-1:0] acc_nxt  [CH];
  logic [AW-1:0] out_sum  [CH];
  logic [AW-1:0] prod_a   [CH];
  logic [AW-1:0] prod_b   [CH];
  logic [CH*DW-1:0] norm_bus;
  logic out_free, accept, flush_go, load, load_last;

  // Handshake: a beat moves on a rising CLK when VALID and READY are both high;
  // VALID never waits on READY, and the output beat is held until taken.
  assign out_free  = !M_VALID || M_READY;
  assign S_READY   = (state == ACC) && out_free;
  assign accept    = S_VALID && S_READY;
  assign W_ENA     = accept;
  assign flush_go  = (state == FLUSH) && !START && out_free;
  assign dbg_state = state;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign prod_a[g] = AW'(S_TDATA[g*DW +: DW]) * AW'(W_A);
    assign prod_b[g] = AW'(S_TDATA[g*DW +: DW]) * AW'(W_B);

    aq_reduce_norm #(.AW(AW), .RW(RW), .DW(DW)) u_norm (
      .sum (out_sum[g]),
      .rcp (RCP),
      .y   (norm_bus[g*DW +: DW])
    );
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_last = 1'b0;
    // START clears before the coincident beat is applied.
    for (int c = 0; c < CH; c++) begin
      acc_base[c] = START ? '0 : acc[c];
      acc_nxt[c]  = acc_base[c];
      out_sum[c]  = acc_base[c];
      if (accept) begin
        if (W_VALID) begin
          out_sum[c] = acc_base[c] + prod_a[c];
          acc_nxt[c] = prod_b[c];
        end else begin
          out_sum[c] = acc_base[c] + prod_b[c];
          acc_nxt[c] = S_TLAST ? '0 : out_sum[c];
        end
      end else if (flush_go) begin
        acc_nxt[c] = '0;
      end
    end

    if (accept) begin
      load      = W_VALID || S_TLAST;
      load_last = S_TLAST && (!W_VALID || (W_B == 16'd0));
    end else if (flush_go) begin
      load      = 1'b1;
      load_last = 1'b1;
    end

    if (START) begin
      state_nxt = ACC;
    end else if (accept && W_VALID && S_TLAST && (W_B != 16'd0)) begin
      state_nxt = FLUSH;
    end else if (flush_go) begin
      state_nxt = ACC;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ACC;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else begin
      state <= state_nxt;
      for (int c = 0; c < CH; c++) acc[c] <= acc_nxt[c];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      M_VALID <= 1'b0;
      M_TDATA <= '0;
      M_TLAST <= 1'b0;
    end else if (load) begin
      M_VALID <= 1'b1;
      M_TDATA <= norm_bus;
      M_TLAST <= load_last;
    end else if (M_READY) begin
      M_VALID <= 1'b0;
    end
  end

endmodule
